bpm_window_ctrl: RTL and testbench

- Measures heart rate by counting beat pulses over a fixed window of WINDOW_SEC seconds.
- At the end of each window it scales the count to beats per minute, publishes the result with a one-cycle valid strobe, and immediately starts the next window.
- Sits between the synchronized pulse-sensor beat line and the display/alarm logic of the health monitor.
- Owns the time base (second prescaler) and the window sequencing.

---
 rtl/hm_pkg.sv | 20 ++
 rtl/beat_edge_detect.sv | 22 ++
 rtl/bpm_window_ctrl.sv | 131 +++++++++++++
 tb/tb_bpm_window_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hm_pkg.sv
// Shared types and constants for the health-monitor beat/BPM logic.
// Holds the window FSM state type, counter widths and the BPM scale helper.
package hm_pkg;

    localparam int BEAT_CNT_W = 6;
    localparam int BPM_W      = 8;

    localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = 6'd63;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        PUBLISH
    } bpm_state_e;

    function automatic int bpm_scale(input int window_sec);
        return 60 / window_sec;
    endfunction

endpackage

// File: rtl/beat_edge_detect.sv
// Rising-edge detector for the synchronized beat level.
// Ports: clk, reset (sync, active-high), beat_in (level), beat_edge (pulse).
module beat_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic beat_in,
    output logic beat_edge
);

    logic beat_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_prev <= 1'b0;
        end else begin
            beat_prev <= beat_in;
        end
    end

    assign beat_edge = beat_in & ~beat_prev;

endmodule

// File: rtl/bpm_window_ctrl.sv
// Counts beats over a fixed window and publishes the scaled rate in BPM.
// Ports: clk, reset (sync, active-high), enable, beat_in -> bpm, bpm_valid,
// saturated, window_active, seconds_left.
module bpm_window_ctrl
    import hm_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int WINDOW_SEC    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             beat_in,
    output logic [BPM_W-1:0] bpm,
    output logic             bpm_valid,
    output logic             saturated,
    output logic             window_active,
    output logic [3:0]       seconds_left
);

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SCALE  = bpm_scale(WINDOW_SEC);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]        SEC_LAST  = 4'(WINDOW_SEC - 1);
    localparam logic [3:0]        WIN_LEN   = 4'(WINDOW_SEC);

    bpm_state_e            state;
    logic [TICK_W-1:0]     tick_cnt;
    logic [3:0]            sec_cnt;
    logic [BEAT_CNT_W-1:0] beat_cnt;

    logic                  beat_edge;
    logic                  sec_tick;
    logic                  win_end;
    logic [BEAT_CNT_W-1:0] beat_cnt_inc;
    logic [13:0]           bpm_prod;
    logic [BPM_W-1:0]      bpm_next;

    beat_edge_detect u_edge (
        .clk       (clk),
        .reset     (reset),
        .beat_in   (beat_in),
        .beat_edge (beat_edge)
    );

    assign sec_tick = (tick_cnt == TICK_LAST);
    assign win_end  = sec_tick && (sec_cnt == SEC_LAST);

    // The edge arriving in the window-end cycle is included in the result.
    assign beat_cnt_inc = (beat_edge && (beat_cnt != BEAT_CNT_MAX))
                        ? beat_cnt + 1'b1 : beat_cnt;

    assign bpm_prod = 14'(beat_cnt_inc) * 14'(SCALE);
    assign bpm_next = (bpm_prod > 14'd255) ? 8'hFF : bpm_prod[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            sec_cnt       <= '0;
            beat_cnt      <= '0;
            bpm           <= '0;
            bpm_valid     <= 1'b0;
            saturated     <= 1'b0;
            window_active <= 1'b0;
            seconds_left  <= '0;
        end else begin
            bpm_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    sec_cnt  <= '0;
                    beat_cnt <= '0;
                    if (enable) begin
                        state         <= COUNT;
                        window_active <= 1'b1;
                        seconds_left  <= WIN_LEN;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        // Partial window is dropped; last result stays.
                        state         <= IDLE;
                        tick_cnt      <= '0;
                        sec_cnt       <= '0;
                        beat_cnt      <= '0;
                        window_active <= 1'b0;
                        seconds_left  <= '0;
                    end else if (win_end) begin
                        state         <= PUBLISH;
                        tick_cnt      <= '0;
                        sec_cnt       <= '0;
                        beat_cnt      <= '0;
                        bpm           <= bpm_next;
                        saturated     <= (beat_cnt_inc == BEAT_CNT_MAX);
                        bpm_valid     <= 1'b1;
                        window_active <= 1'b0;
                        seconds_left  <= '0;
                    end else begin
                        beat_cnt <= beat_cnt_inc;
                        if (sec_tick) begin
                            tick_cnt     <= '0;
                            sec_cnt      <= sec_cnt + 4'd1;
                            seconds_left <= WIN_LEN - sec_cnt - 4'd1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                PUBLISH: begin
                    tick_cnt <= '0;
                    sec_cnt  <= '0;
                    // An edge during publish opens the next window at 1.
                    beat_cnt <= {{(BEAT_CNT_W-1){1'b0}}, enable & beat_edge};
                    if (enable) begin
                        state         <= COUNT;
                        window_active <= 1'b1;
                        seconds_left  <= WIN_LEN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bpm_window_ctrl.sv
// Randomized self-checking bench for bpm_window_ctrl (16 ticks/s, 15 s).
// Window results are predicted by counting rising edges of the driven beat.
module tb_bpm_window_ctrl;

    localparam int TPS = 16;
    localparam int WIN = 15;
    localparam int LEN = TPS * WIN;

    typedef logic pat_t [LEN];

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       beat_in;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic       saturated;
    logic       window_active;
    logic [3:0] seconds_left;

    int   vectors     = 0;
    int   miscompares = 0;
    logic last_beat   = 1'b0;
    int   last_bpm    = 0;

    bpm_window_ctrl #(
        .TICKS_PER_SEC (TPS),
        .WINDOW_SEC    (WIN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .beat_in       (beat_in),
        .bpm           (bpm),
        .bpm_valid     (bpm_valid),
        .saturated     (saturated),
        .window_active (window_active),
        .seconds_left  (seconds_left)
    );

    always #5 clk = ~clk;

    // One clock: drive at negedge, let posedge sample, return at negedge.
    task automatic step(input logic rst, input logic en, input logic b);
        reset   = rst;
        enable  = en;
        beat_in = b;
        @(posedge clk);
        last_beat = rst ? 1'b0 : b;
        @(negedge clk);
    endtask

    function automatic int rate_of(input int edges);
        int n;
        n = (edges > 63) ? 63 : edges;
        return n * (60 / WIN);
    endfunction

    task automatic make_pulses(output pat_t p, input int n, input int hi,
                               input int lo, input int start);
        for (int k = 0; k < LEN; k++) p[k] = 1'b0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < hi; j++)
                if (start + i * (hi + lo) + j < LEN)
                    p[start + i * (hi + lo) + j] = 1'b1;
    endtask

    task automatic make_rand(output pat_t p, input int density);
        for (int k = 0; k < LEN; k++)
            p[k] = ($urandom_range(0, 99) < density) ? 1'b1 : 1'b0;
    endtask

    // Caller guarantees the DUT has just entered a counting window.
    task automatic run_window(input string tag, input pat_t pat,
                              input int carry, input logic en_after,
                              input logic pub_beat, output int carry_out);
        int edges;
        int exp_b;
        edges = carry;
        for (int k = 0; k < LEN; k++) begin
            vectors += 3;
            if (window_active !== 1'b1) begin
                miscompares++;
                $display("FAIL %s active k=%0d got %b exp 1",
                         tag, k, window_active);
            end
            if (seconds_left !== 4'(WIN - k / TPS)) begin
                miscompares++;
                $display("FAIL %s seconds_left k=%0d got %0d exp %0d",
                         tag, k, seconds_left, WIN - k / TPS);
            end
            if (bpm_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s early valid k=%0d got %b exp 0",
                         tag, k, bpm_valid);
            end
            if (pat[k] && !last_beat) edges++;
            step(1'b0, 1'b1, pat[k]);
        end
        exp_b = rate_of(edges);
        last_bpm = exp_b;
        vectors += 5;
        if (bpm_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s valid got %b exp 1", tag, bpm_valid);
        end
        if (bpm !== 8'(exp_b)) begin
            miscompares++;
            $display("FAIL %s bpm got %0d exp %0d", tag, bpm, exp_b);
        end
        if (saturated !== (edges >= 63)) begin
            miscompares++;
            $display("FAIL %s saturated got %b exp %b",
                     tag, saturated, edges >= 63);
        end
        if (window_active !== 1'b0) begin
            miscompares++;
            $display("FAIL %s publish active got %b exp 0", tag, window_active);
        end
        if (seconds_left !== 4'd0) begin
            miscompares++;
            $display("FAIL %s publish secs got %0d exp 0", tag, seconds_left);
        end
        carry_out = (en_after && pub_beat && !last_beat) ? 1 : 0;
        step(1'b0, en_after, pub_beat);
        vectors++;
        if (bpm_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s strobe width got %b exp 0", tag, bpm_valid);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        beat_in = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'(i % 2 == 0));
            vectors += 5;
            if (bpm !== 8'd0 || bpm_valid !== 1'b0 || saturated !== 1'b0 ||
                window_active !== 1'b0 || seconds_left !== 4'd0) begin
                miscompares++;
                $display("FAIL reset i=%0d got bpm=%0d v=%b s=%b a=%b sl=%0d exp 0",
                         i, bpm, bpm_valid, saturated, window_active,
                         seconds_left);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (window_active !== 1'b0) begin
            miscompares++;
            $display("FAIL idle active got %b exp 0", window_active);
        end
    endtask

    task automatic test_normal();
        pat_t p;
        int   c;
        step(1'b0, 1'b1, 1'b0);
        make_pulses(p, 18, 4, 8, 2);
        run_window("normal", p, 0, 1'b1, 1'b0, c);
        vectors++;
        if (last_bpm != 72) begin
            miscompares++;
            $display("FAIL normal model got %0d exp 72", last_bpm);
        end
    endtask

    task automatic test_saturation();
        pat_t p;
        int   c;
        for (int k = 0; k < LEN; k++) p[k] = 1'(k % 2 == 0);
        run_window("sat", p, 0, 1'b1, 1'b0, c);
        make_pulses(p, 10, 4, 8, 5);
        run_window("after_sat", p, c, 1'b1, 1'b0, c);
    endtask

    task automatic test_abort();
        pat_t p;
        int   c;
        make_pulses(p, 18, 4, 8, 2);
        run_window("pre_abort", p, 0, 1'b1, 1'b0, c);
        for (int k = 0; k < 100; k++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            vectors += 4;
            if (window_active !== 1'b0 || seconds_left !== 4'd0) begin
                miscompares++;
                $display("FAIL abort status got a=%b sl=%0d exp 0",
                         window_active, seconds_left);
            end
            if (bpm_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort valid got %b exp 0", bpm_valid);
            end
            if (bpm !== 8'd72) begin
                miscompares++;
                $display("FAIL abort bpm got %0d exp 72", bpm);
            end
            step(1'b0, 1'b0, 1'b1);
        end
        // Beat level already high as enable rises.
        step(1'b0, 1'b1, 1'b1);
        make_pulses(p, 7, 4, 8, 0);
        run_window("restart", p, 0, 1'b1, 1'b0, c);
    endtask

    task automatic test_boundary();
        pat_t p;
        int   c;
        make_pulses(p, 5, 4, 8, 10);
        p[LEN-1] = 1'b1;
        run_window("last_cycle", p, 0, 1'b1, 1'b0, c);
        make_pulses(p, 5, 4, 8, 10);
        run_window("pre_pub", p, 0, 1'b1, 1'b1, c);
        for (int k = 0; k < LEN; k++) p[k] = 1'b0;
        run_window("pub_edge", p, c, 1'b1, 1'b0, c);
        vectors++;
        if (last_bpm != 4) begin
            miscompares++;
            $display("FAIL boundary model got %0d exp 4", last_bpm);
        end
    endtask

    task automatic test_reset_mid();
        pat_t p;
        int   c;
        make_pulses(p, 18, 4, 8, 2);
        run_window("pre_reset", p, 0, 1'b1, 1'b0, c);
        for (int k = 0; k < 120; k++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1, 1'b0);
        vectors += 3;
        if (bpm !== 8'd0 || saturated !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset bpm got %0d/%b exp 0/0", bpm, saturated);
        end
        if (window_active !== 1'b0 || seconds_left !== 4'd0) begin
            miscompares++;
            $display("FAIL midreset state got a=%b sl=%0d exp 0",
                     window_active, seconds_left);
        end
        if (bpm_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset valid got %b exp 0", bpm_valid);
        end
        step(1'b0, 1'b1, 1'b0);
        make_rand(p, 30);
        run_window("post_reset", p, 0, 1'b1, 1'b0, c);
    endtask

    task automatic test_drop_at_end();
        int prev;
        prev = last_bpm;
        for (int k = 0; k < LEN - 1; k++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0, 1'b1);
        vectors += 3;
        if (bpm_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_end valid got %b exp 0", bpm_valid);
        end
        if (bpm !== 8'(prev)) begin
            miscompares++;
            $display("FAIL drop_end bpm got %0d exp %0d", bpm, prev);
        end
        if (window_active !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_end active got %b exp 0", window_active);
        end
    endtask

    task automatic test_random();
        pat_t p;
        int   c;
        logic pb;
        c = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int w = 0; w < 5; w++) begin
            make_rand(p, int'($urandom_range(3, 95)));
            pb = 1'($urandom_range(0, 1));
            run_window("random", p, c, 1'(w != 4), pb, c);
        end
        vectors++;
        if (window_active !== 1'b0) begin
            miscompares++;
            $display("FAIL random idle active got %b exp 0", window_active);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_saturation();
        test_abort();
        test_boundary();
        test_reset_mid();
        test_drop_at_end();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
